// File: rtl/nx_stream_arbiter.sv
// Merges the four inbound mesh links of an nx_node through per-direction FIFOs into one tagged stream.
// Build option NX_ARB_ROUND_ROBIN_EN selects round-robin; the default build uses fixed priority N > E > S > W.
module nx_stream_arbiter #(
  parameter int STREAM_WIDTH = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [STREAM_WIDTH-1:0] ib_north_data_i,
  input  logic                    ib_north_valid_i,
  output logic                    ib_north_ready_o,
  input  logic [STREAM_WIDTH-1:0] ib_east_data_i,
  input  logic                    ib_east_valid_i,
  output logic                    ib_east_ready_o,
  input  logic [STREAM_WIDTH-1:0] ib_south_data_i,
  input  logic                    ib_south_valid_i,
  output logic                    ib_south_ready_o,
  input  logic [STREAM_WIDTH-1:0] ib_west_data_i,
  input  logic                    ib_west_valid_i,
  output logic                    ib_west_ready_o,
  output logic [STREAM_WIDTH-1:0] arb_data_o,
  output logic [1:0]              arb_dir_o,
  output logic                    arb_valid_o,
  input  logic                    arb_ready_i,
  output logic                    idle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [STREAM_WIDTH-1:0] in_data [4];
  logic [3:0]              in_valid;
  logic [3:0]              ready;
  logic [3:0]              push;
  logic [3:0]              pop;
  logic [3:0]              nonempty;
  logic [STREAM_WIDTH-1:0] mem [4][FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr [4];
  logic [PTR_W-1:0]        rd_ptr [4];
  logic [CNT_W-1:0]        count [4];
  logic [CNT_W-1:0]        count_next [4];
  logic                    advance;
  logic                    grant_any;
  logic [1:0]              grant_dir;

  assign in_data[0] = ib_north_data_i;
  assign in_data[1] = ib_east_data_i;
  assign in_data[2] = ib_south_data_i;
  assign in_data[3] = ib_west_data_i;
  assign in_valid   = {ib_west_valid_i, ib_south_valid_i, ib_east_valid_i, ib_north_valid_i};

  assign ib_north_ready_o = ready[0];
  assign ib_east_ready_o  = ready[1];
  assign ib_south_ready_o = ready[2];
  assign ib_west_ready_o  = ready[3];

  // The slot may take a new word when it is empty or being drained this cycle.
  assign advance = !arb_valid_o || arb_ready_i;
  assign idle_o  = !(|nonempty) && !arb_valid_o;

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      nonempty[d] = (count[d] != '0);
    end
  end

`ifdef NX_ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant;
  logic [1:0] cand;

  always_comb begin
    grant_any = 1'b0;
    grant_dir = 2'd0;
    cand      = 2'd0;
    // Search wraps from the direction after the last grant; i == 4 revisits last_grant itself.
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_any && nonempty[cand]) begin
        grant_any = 1'b1;
        grant_dir = cand;
      end
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_any = 1'b1;
        grant_dir = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      push[d]       = in_valid[d] && ready[d];
      pop[d]        = advance && grant_any && (grant_dir == 2'(d));
      count_next[d] = count[d] + CNT_W'(push[d]) - CNT_W'(pop[d]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int d = 0; d < 4; d++) begin
      if (push[d]) begin
        mem[d][wr_ptr[d]] <= in_data[d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int d = 0; d < 4; d++) begin
        count[d]  <= '0;
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
      end
      ready       <= 4'b0000;
      arb_valid_o <= 1'b0;
      arb_data_o  <= '0;
      arb_dir_o   <= 2'd0;
`ifdef NX_ARB_ROUND_ROBIN_EN
      last_grant  <= 2'd3;
`endif
    end else begin
      // Ready reflects the occupancy after this edge, so a popped full FIFO reopens one cycle later.
      for (int d = 0; d < 4; d++) begin
        count[d] <= count_next[d];
        ready[d] <= (count_next[d] < DEPTH_CNT);
        if (push[d]) begin
          wr_ptr[d] <= wr_ptr[d] + PTR_W'(1);
        end
        if (pop[d]) begin
          rd_ptr[d] <= rd_ptr[d] + PTR_W'(1);
        end
      end
      if (advance) begin
        arb_valid_o <= grant_any;
        if (grant_any) begin
          arb_data_o <= mem[grant_dir][rd_ptr[grant_dir]];
          arb_dir_o  <= grant_dir;
        end
      end
`ifdef NX_ARB_ROUND_ROBIN_EN
      if (advance && grant_any) begin
        last_grant <= grant_dir;
      end
`endif
    end
  end

  // A link must never present a word while its ready is low: that word would be silently lost.
  for (genvar d = 0; d < 4; d++) begin : g_drop_chk
    a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_i) !(in_valid[d] && !ready[d]));
  end

endmodule
